apb_completer_regfile: RTL and testbench
========================================

Name: apb_completer_regfile

Overview:
- APB completer: the far end of the AHB-to-APB bridge. It responds to the bridge's Pselx/Penable/Pwrite/Paddr/Pwdata and returns Prdata.
- Implements a bank of NUM_REGS 32-bit read/write registers behind one Pselx slot.
- Drives Pready and Pslverr, so benches and system models have a real peripheral to target.
- One instance per slot; four instances cover Pselx[3:0].

Parameters:
- SLOT_ID, 0: index of the Pselx bit that selects this instance (0..3).
- BASE_ADDR, 32'h8000_0000: byte address of register 0.
- NUM_REGS, 16: number of 32-bit registers, power of 2, range 2..256.
- WAIT_CYCLES, 2: wait states inserted per access; used only when APB_WAIT_STATE_EN is defined. Range 0..15.
- RESET_VAL, 32'h0000_0000: reset value of every register.

Ports:
- clock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- Pselx  input  4  one-hot peripheral select; this block uses Pselx[SLOT_ID] only.
- Penable  input  1  APB access-phase indicator.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address.
- Pwdata  input  32  write data.
- Prdata  output  32  read data; valid only when Pready=1 in the access phase.
- Pready  output  1  transfer-completion handshake.
- Pslverr  output  1  error response; valid only when Pready=1.

Behaviour:
- Reset values (asynchronous, while reset=1): all registers = RESET_VAL, Prdata=0, Pready=0, Pslverr=0, FSM=IDLE, wait counter=0.
- Local select: sel = Pselx[SLOT_ID].
- Address decode:
  - off = Paddr - BASE_ADDR.
  - The access is in range when off[1:0]==0 and off < 4*NUM_REGS.
  - idx = off[2 +: $clog2(NUM_REGS)].
  - An unaligned or out-of-range address is an error.
- FSM states: IDLE, SETUP, WAIT, ACCESS.
  - IDLE: sel=1 & Penable=0 -> SETUP. Latch Pwrite, idx, err and Pwdata. On a read, also latch Prdata_next = err ? 0 : reg[idx].
  - SETUP: next cycle requires sel=1 & Penable=1. If the wait count is 0 -> ACCESS with Pready=1; otherwise -> WAIT with the counter loaded.
  - WAIT: Pready=0; the counter decrements each cycle; at 1 -> ACCESS.
  - ACCESS: Pready=1, Pslverr=err, Prdata=latched read data (0 on write or error). The write commits to reg[idx] on this edge if no error. Next state: sel=1 & Penable=0 -> SETUP (back-to-back); otherwise -> IDLE.
- Pready, Pslverr and Prdata are registered and asserted exactly in the ACCESS cycle; they are 0 in every other cycle.
- Latency: zero-wait access takes 2 cycles (SETUP, ACCESS); with N waits it takes 2+N cycles.
- A write with an error leaves all registers unchanged and returns Pslverr=1. A read with an error returns Prdata=0 and Pslverr=1.
- Protocol violations:
  - Penable=1 while in IDLE: ignored, stays IDLE, no response.
  - sel dropping in SETUP or WAIT: abort to IDLE, no register update, no response.
  - Paddr, Pwrite or Pwdata changing during WAIT: ignored; the values latched in SETUP are used.
- Pselx with multiple bits set: this block responds if its own bit is set; the error is not flagged.
- Reset mid-transfer: immediate return to IDLE with outputs 0. A pending write is lost.

Optional Feature:
- Macro: APB_WAIT_STATE_EN.
- Defined: WAIT_CYCLES wait states are inserted on every access via the WAIT state and a 4-bit counter.
- Undefined: the WAIT state and counter are not built; every access is zero-wait and WAIT_CYCLES is ignored.

Decomposition:
- Package apb_completer_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} apb_state_e;
  - APB_DATA_W=32, APB_ADDR_W=32, APB_SEL_W=4.
  - localparam function for the index width.
- One sub-module, apb_addr_decode: combinational off/idx/err computation from Paddr, BASE_ADDR and NUM_REGS; reusable by other APB peripherals.
- The register array and FSM stay in the top module.

Test Plan:
- Reset: assert reset mid-run -> Prdata=0, Pready=0, Pslverr=0 within the same cycle. After release, a read of 0x8000_0000 returns RESET_VAL.
- Zero-wait write/read: write 0xDEAD_BEEF to 0x8000_0008, then read the same address -> Pready high in the 2nd cycle of each transfer, Prdata=0xDEAD_BEEF, Pslverr=0.
- Wait states (APB_WAIT_STATE_EN, WAIT_CYCLES=3): a read takes 5 cycles, with Pready=0 for exactly 3 cycles after SETUP. A mid-WAIT change of Pwdata/Paddr has no effect.
- Errors:
  - Write to 0x8000_0040 (NUM_REGS=16) -> Pslverr=1 and no register changes.
  - Read of 0x8000_0002 -> Pslverr=1, Prdata=0.
- Back-to-back: three writes with SETUP immediately after ACCESS -> three Pready pulses spaced 2 cycles apart, and all three registers are updated.
- Slot isolation: SLOT_ID=2 with a Pselx=4'b0001 transfer -> no response and registers unchanged. Penable=1 without a prior setup -> ignored.

Source files
------------

// File: rtl/apb_completer_pkg.sv
// Shared types and widths for the APB completer register file and its decoder.
package apb_completer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } apb_state_e;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam int APB_SEL_W  = 4;

  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Word-register address decoder: offset from a base, register index and
// unaligned/out-of-range error flag. Purely combinational.
module apb_addr_decode
  import apb_completer_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                    NUM_REGS  = 16,
  parameter int                    IDX_W     = idx_width(NUM_REGS)
) (
  input  logic [APB_ADDR_W-1:0] paddr_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  err_o
);

  localparam logic [APB_ADDR_W-1:0] SPAN = APB_ADDR_W'(NUM_REGS * 4);

  logic [APB_ADDR_W-1:0] off_s;

  // Addresses below the base wrap to a large offset and fail the span check.
  always_comb begin
    off_s = paddr_i - BASE_ADDR;
    err_o = (off_s[1:0] != 2'b00) || (off_s >= SPAN);
    idx_o = off_s[2 +: IDX_W];
  end

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer with NUM_REGS 32-bit read/write registers behind one Pselx slot.
// Define APB_WAIT_STATE_EN to insert WAIT_CYCLES wait states on every access.
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int unsigned           SLOT_ID     = 0,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [APB_SEL_W-1:0]  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int         IDX_W    = idx_width(NUM_REGS);
  localparam logic [1:0] SLOT_IDX = 2'(SLOT_ID);

  if ((SLOT_ID >= 32'd4) || (NUM_REGS < 32'd2) || (NUM_REGS > 32'd256) ||
      ((NUM_REGS & (NUM_REGS - 32'd1)) != 32'd0) || (WAIT_CYCLES > 32'd15)) begin : g_param_check
    $error("apb_completer_regfile: parameter out of range");
  end

  apb_state_e            state_q;
  logic [APB_DATA_W-1:0] regs_q [NUM_REGS];

  logic                  wr_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_DATA_W-1:0] rdata_q;
  logic [APB_DATA_W-1:0] rdata_d;

  logic                  sel_s;
  logic                  start_s;
  logic                  latch_s;
  logic                  commit_s;
  logic                  go_access_s;
  logic [IDX_W-1:0]      dec_idx_s;
  logic                  dec_err_s;
  logic                  unused_sel_s;

`ifdef APB_WAIT_STATE_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q;
`endif

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_decode (
    .paddr_i (Paddr),
    .idx_o   (dec_idx_s),
    .err_o   (dec_err_s)
  );

  assign unused_sel_s = ^Pselx;

  // Handshake qualifiers, write commit and read-data capture with write forwarding.
  always_comb begin
    sel_s    = Pselx[SLOT_IDX];
    start_s  = sel_s && !Penable;
    latch_s  = start_s && ((state_q == IDLE) || (state_q == ACCESS));
    commit_s = (state_q == ACCESS) && wr_q && !err_q;
    // A back-to-back read of the register being committed sees the new value.
    if (Pwrite || dec_err_s) begin
      rdata_d = {APB_DATA_W{1'b0}};
    end else if (commit_s && (idx_q == dec_idx_s)) begin
      rdata_d = wdata_q;
    end else begin
      rdata_d = regs_q[dec_idx_s];
    end
`ifdef APB_WAIT_STATE_EN
    go_access_s = ((state_q == SETUP) && sel_s && Penable && (WAIT_LOAD == 4'd0)) ||
                  ((state_q == WAIT) && sel_s && (cnt_q == 4'd1));
`else
    go_access_s = (state_q == SETUP) && sel_s && Penable;
`endif
  end

  // Transfer attributes captured in the setup phase and held to completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      wdata_q <= {APB_DATA_W{1'b0}};
      rdata_q <= {APB_DATA_W{1'b0}};
    end else if (latch_s) begin
      wr_q    <= Pwrite;
      err_q   <= dec_err_s;
      idx_q   <= dec_idx_s;
      wdata_q <= Pwdata;
      rdata_q <= rdata_d;
    end
  end

  // Register bank; a write lands on the edge that ends the ACCESS cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (commit_s) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

  // Transfer FSM with registered response outputs, live only in ACCESS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= {APB_DATA_W{1'b0}};
`ifdef APB_WAIT_STATE_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      Pready  <= go_access_s;
      Pslverr <= go_access_s && err_q;
      Prdata  <= go_access_s ? rdata_q : {APB_DATA_W{1'b0}};
      case (state_q)
        IDLE: state_q <= start_s ? SETUP : IDLE;
        SETUP: begin
          if (!(sel_s && Penable)) begin
            state_q <= IDLE;
          end else if (go_access_s) begin
            state_q <= ACCESS;
          end else begin
            state_q <= WAIT;
`ifdef APB_WAIT_STATE_EN
            cnt_q   <= WAIT_LOAD;
`endif
          end
        end
`ifdef APB_WAIT_STATE_EN
        WAIT: begin
          if (!sel_s) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else if (go_access_s) begin
            state_q <= ACCESS;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
`else
        WAIT: state_q <= IDLE;
`endif
        ACCESS: state_q <= start_s ? SETUP : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Self-checking bench for apb_completer_regfile: APB master tasks with a
// response scoreboard and a reference register image.
module tb_apb_completer_regfile;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam logic [31:0] RST_VAL = 32'hC0DE_0000;
  localparam logic [3:0]  MY_SEL  = 4'b0100;
`ifdef APB_WAIT_STATE_EN
  localparam int EXP_WAITS = 3;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  Pselx   = 4'b0000;
  logic        Penable = 1'b0;
  logic        Pwrite  = 1'b0;
  logic [31:0] Paddr   = 32'h0;
  logic [31:0] Pwdata  = 32'h0;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          ready_cyc   = 0;
  logic [31:0] model [16];
  logic [32:0] sb_q [$];

  apb_completer_regfile #(
    .SLOT_ID     (2),
    .BASE_ADDR   (BASE),
    .NUM_REGS    (16),
    .WAIT_CYCLES (3),
    .RESET_VAL   (RST_VAL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .Pselx   (Pselx),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .Pready  (Pready),
    .Pslverr (Pslverr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off[1:0] == 2'b00) && (off < 32'd64);
  endfunction

  function automatic int addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[5:2]);
  endfunction

  // Full transfer; returns in the ACCESS cycle with the bus still in access phase.
  task automatic xfer(input logic [3:0] psel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit corrupt);
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [32:0] e;
    int          waits;
    exp_err = !addr_ok(addr);
    if (wr) begin
      exp_rd = 32'h0;
      if (!exp_err) model[addr_idx(addr)] = wdata;
    end else begin
      exp_rd = exp_err ? 32'h0 : model[addr_idx(addr)];
    end
    sb_q.push_back({exp_err, exp_rd});
    Pselx = psel; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wdata;
    @(posedge clock); #1;
    Penable = 1'b1;
    if (corrupt) begin
      Paddr = addr ^ 32'h0000_0004; Pwdata = ~wdata; Pwrite = ~wr;
    end
    waits = 0;
    forever begin
      @(posedge clock); #1;
      if (Pready === 1'b1) break;
      waits++;
      if (waits > 40) begin
        vectors++; miscompares++;
        $display("FAIL timeout addr=%h: Pready never rose", addr);
        void'(sb_q.pop_front());
        return;
      end
    end
    ready_cyc = cyc;
    e = sb_q.pop_front();
    vectors++;
    if (waits !== EXP_WAITS) begin
      miscompares++;
      $display("FAIL latency addr=%h: got %0d wait cycles, expected %0d", addr, waits, EXP_WAITS);
    end
    vectors++;
    if (Pslverr !== e[32]) begin
      miscompares++;
      $display("FAIL pslverr addr=%h: got %b, expected %b", addr, Pslverr, e[32]);
    end
    vectors++;
    if (Prdata !== e[31:0]) begin
      miscompares++;
      $display("FAIL prdata addr=%h: got %h, expected %h", addr, Prdata, e[31:0]);
    end
  endtask

  task automatic bus_idle();
    Pselx = 4'b0000; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h0; Pwdata = 32'h0;
    @(posedge clock); #1;
    vectors++;
    if (Pready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_pulse: Pready=%b after ACCESS, expected 0", Pready);
    end
  endtask

  task automatic expect_silent(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (Pready !== 1'b0 || Pslverr !== 1'b0 || Prdata !== 32'h0) begin
        miscompares++;
        $display("FAIL %s: rdy=%b err=%b rdata=%h, expected all 0", name, Pready, Pslverr, Prdata);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clock); @(posedge clock); #1;
    vectors++;
    if (Pready !== 1'b0 || Pslverr !== 1'b0 || Prdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b err=%b rdata=%h, expected 0", Pready, Pslverr, Prdata);
    end
    for (int i = 0; i < 16; i++) model[i] = RST_VAL;
    reset = 1'b0;
    @(posedge clock); #1;
    xfer(MY_SEL, 1'b0, BASE, 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_zero_wait();
    xfer(MY_SEL, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 1'b0);
    bus_idle();
    xfer(MY_SEL, 1'b0, BASE + 32'h8, 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_errors();
    xfer(MY_SEL, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 1'b0);
    bus_idle();
    xfer(MY_SEL, 1'b0, 32'h8000_0002, 32'h0, 1'b0);
    bus_idle();
    xfer(MY_SEL, 1'b1, 32'h7FFF_FFFC, 32'h1111_1111, 1'b0);
    bus_idle();
    xfer(MY_SEL, 1'b1, 32'h8000_003C, 32'h3C3C_3C3C, 1'b0);
    bus_idle();
    for (int i = 0; i < 16; i++) xfer(MY_SEL, 1'b0, BASE + 32'(4 * i), 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    xfer(MY_SEL, 1'b1, BASE + 32'h24, 32'h9999_0001, 1'b0); c1 = ready_cyc;
    xfer(MY_SEL, 1'b1, BASE + 32'h28, 32'hAAAA_0002, 1'b0); c2 = ready_cyc;
    vectors++;
    if (c2 - c1 !== 2 + EXP_WAITS) begin
      miscompares++;
      $display("FAIL b2b_spacing1: got %0d cycles, expected %0d", c2 - c1, 2 + EXP_WAITS);
    end
    xfer(MY_SEL, 1'b1, BASE + 32'h2C, 32'hBBBB_0003, 1'b0);
    vectors++;
    if (ready_cyc - c2 !== 2 + EXP_WAITS) begin
      miscompares++;
      $display("FAIL b2b_spacing2: got %0d cycles, expected %0d", ready_cyc - c2, 2 + EXP_WAITS);
    end
    xfer(MY_SEL, 1'b0, BASE + 32'h2C, 32'h0, 1'b0);
    xfer(MY_SEL, 1'b0, BASE + 32'h24, 32'h0, 1'b0);
    xfer(MY_SEL, 1'b0, BASE + 32'h28, 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_latched_hold();
    xfer(MY_SEL, 1'b1, BASE + 32'h10, 32'h1357_9BDF, 1'b1);
    bus_idle();
    xfer(MY_SEL, 1'b0, BASE + 32'h10, 32'h0, 1'b0);
    xfer(MY_SEL, 1'b0, BASE + 32'h14, 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_slot_isolation();
    xfer(MY_SEL, 1'b1, BASE + 32'hC, 32'h0C0C_0C0C, 1'b0);
    bus_idle();
    Pselx = 4'b0001; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'hC; Pwdata = 32'hBAD0_000C;
    @(posedge clock); #1;
    Penable = 1'b1;
    expect_silent("slot_isolation", 3);
    bus_idle();
    Pselx = MY_SEL; Penable = 1'b1; Pwrite = 1'b1; Paddr = BASE + 32'h10; Pwdata = 32'hBAD0_0010;
    expect_silent("penable_only", 3);
    bus_idle();
    xfer(MY_SEL, 1'b0, BASE + 32'hC, 32'h0, 1'b0);
    xfer(MY_SEL, 1'b0, BASE + 32'h10, 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_abort();
    xfer(MY_SEL, 1'b1, BASE + 32'h14, 32'h0505_0505, 1'b0);
    bus_idle();
    Pselx = MY_SEL; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h14; Pwdata = 32'h5555_AAAA;
    @(posedge clock); #1;
    Pselx = 4'b0000;
    expect_silent("abort", 3 + EXP_WAITS);
    xfer(MY_SEL, 1'b0, BASE + 32'h14, 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_multi_sel();
    xfer(4'b0111, 1'b1, BASE + 32'h1C, 32'h7777_0007, 1'b0);
    bus_idle();
    xfer(4'b1100, 1'b0, BASE + 32'h1C, 32'h0, 1'b0);
    bus_idle();
  endtask

  task automatic test_reset_mid();
    xfer(MY_SEL, 1'b1, BASE + 32'h4, 32'h2222_2222, 1'b0);
    xfer(MY_SEL, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
    reset = 1'b1;
    #1;
    vectors++;
    if (Pready !== 1'b0 || Pslverr !== 1'b0 || Prdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: rdy=%b err=%b rdata=%h, expected 0", Pready, Pslverr, Prdata);
    end
    Pselx = 4'b0000; Penable = 1'b0; Pwrite = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = RST_VAL;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    xfer(MY_SEL, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
    xfer(MY_SEL, 1'b0, BASE + 32'h8, 32'h0, 1'b0);
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_errors();
    test_back_to_back();
    test_latched_hold();
    test_slot_isolation();
    test_abort();
    test_multi_sel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
